// File: rtl/truth_table_sweeper.sv
// Drives a 3-input combinational block through all eight input vectors, samples its output
// after a programmable settle time and assembles the results into a truth-table byte.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'h73
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       out_dut,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match,
  output logic [7:0] mismatch_mask
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_vec, w_vec_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_shadow, w_shadow_nxt;
  logic [7:0]       r_table, w_table_nxt;
  logic             r_match, w_match_nxt;
  logic [7:0]       r_mask, w_mask_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_vec    <= 3'd0;
      r_cnt    <= '0;
      r_shadow <= 8'h00;
      r_table  <= 8'h00;
      r_match  <= 1'b0;
      r_mask   <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vec    <= w_vec_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_table  <= w_table_nxt;
      r_match  <= w_match_nxt;
      r_mask   <= w_mask_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; vector k lands in bit 7-k, i.e. bit ~k
  always_comb begin
    w_state_nxt  = r_state;
    w_vec_nxt    = r_vec;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_table_nxt  = r_table;
    w_match_nxt  = r_match;
    w_mask_nxt   = r_mask;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt  = S_APPLY;
          w_vec_nxt    = 3'd0;
          w_cnt_nxt    = '0;
          w_shadow_nxt = 8'h00;
        end
      end
      S_APPLY: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_vec_nxt   = 3'd0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt             = '0;
          w_shadow_nxt[~r_vec]  = out_dut;
          if (r_vec == 3'd7) begin
            w_state_nxt = S_DONE;
            w_table_nxt = w_shadow_nxt;
            w_match_nxt = (w_shadow_nxt == EXPECTED);
            w_mask_nxt  = w_shadow_nxt ^ EXPECTED;
          end else begin
            w_vec_nxt = r_vec + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_APPLY);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign in1           = r_vec[2];
  assign in2           = r_vec[1];
  assign in3           = r_vec[0];
  assign busy          = r_busy;
  assign done          = r_done;
  assign table_out     = r_table;
  assign match         = r_match;
  assign mismatch_mask = r_mask;

endmodule
